// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions used by the fetch stage: NOP encoding and the
// {pc, instr} entry carried from fetch toward IF/ID.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; push is accepted when full only if a pop
// happens in the same cycle, so occupancy stays unchanged in that case.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order memory requests, tracks their PCs, queues
// returned words toward IF/ID, and discards responses made stale by a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          IMEM_AW  = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               stall,
    output logic               imem_req_valid,
    output logic [IMEM_AW-1:0] imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic               misalign_err,
    output logic [31:0]        pc_debug
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_discard;

    logic          w_q_empty;
    logic [CW-1:0] w_q_count;
    fetch_entry_t  w_q_head;
    fetch_entry_t  w_q_in;
    logic          w_if_empty;
    logic [CW-1:0] w_if_count;
    logic [31:0]   w_if_head;

    logic          w_pop;
    logic          w_req_fire;
    logic          w_rsp_keep;
    logic          w_rsp_drop;
    logic [CW+1:0] w_total;
    logic [CW+1:0] w_credit;
    logic [CW:0]   w_outstanding;
    logic [CW:0]   w_discard_load;

    assign w_pop      = out_valid && out_ready;
    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_keep = imem_rsp_valid && !redirect_valid && (r_discard == '0) && !w_if_empty;
    assign w_rsp_drop = imem_rsp_valid && !redirect_valid && (r_discard != '0);

    // A pop this cycle frees a slot in time for a response no earlier than next cycle.
    assign w_total  = {2'b00, w_q_count} + {2'b00, w_if_count} + {2'b00, r_discard};
    assign w_credit = w_total - {{(CW+1){1'b0}}, w_pop};

    assign imem_req_valid = !rst_n && !stall && !redirect_valid && (w_credit < (CW+2)'(DEPTH));
    assign imem_req_addr  = r_pc[IMEM_AW-1:0];

    // A response arriving in the redirect cycle retires one of the outstanding requests.
    assign w_outstanding  = {1'b0, r_discard} + {1'b0, w_if_count};
    assign w_discard_load = (imem_rsp_valid && (w_outstanding != '0)) ? w_outstanding - (CW+1)'(1)
                                                                     : w_outstanding;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_pc      <= RESET_PC;
            r_discard <= '0;
        end else if (redirect_valid) begin
            r_pc      <= align_pc(redirect_pc);
            r_discard <= w_discard_load[CW-1:0];
        end else begin
            if (w_req_fire) r_pc      <= r_pc + 32'd4;
            if (w_rsp_drop) r_discard <= r_discard - CW'(1);
        end
    end

    assign w_q_in = '{pc: w_if_head, instr: imem_rsp_data};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_rsp_keep),
        .i_data  (w_q_in),
        .i_pop   (w_pop),
        .o_data  (w_q_head),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_inflight (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_req_fire),
        .i_data  (r_pc),
        .i_pop   (w_rsp_keep),
        .o_data  (w_if_head),
        .o_empty (w_if_empty),
        .o_count (w_if_count)
    );

    assign out_valid    = !w_q_empty;
    assign out_instr    = w_q_empty ? NOP_INSTR : w_q_head.instr;
    assign out_pc       = w_q_empty ? 32'h0 : w_q_head.pc;
    assign misalign_err = !rst_n && redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign pc_debug     = r_pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; the PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2; the instruction queue depth (allowed range 2..4).
REQ-003 SHALL have parameter IMEM_AW, default 13; the instruction-memory byte-address width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-high (asserted at 1).
REQ-006 redirect_valid  input  1  branch/jump taken in EX; replaces PC and flushes fetch.
REQ-007 redirect_pc  input  32  redirect target.
REQ-008 stall  input  1  hazard hold; blocks new memory requests only.
REQ-009 imem_req_valid  output  1  fetch request.
REQ-010 imem_req_addr  output  IMEM_AW  request byte address = pc[IMEM_AW-1:0].
REQ-011 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-012 imem_rsp_valid  input  1  in-order response, at least 1 cycle after acceptance.
REQ-013 imem_rsp_data  input  32  instruction word.
REQ-014 out_valid  output  1  queue head valid toward IF/ID.
REQ-015 out_ready  input  1  IF/ID accepts the head.
REQ-016 out_instr  output  32  head instruction.
REQ-017 out_pc  output  32  head PC.
REQ-018 misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0.
REQ-019 pc_debug  output  32  current fetch PC register.

Function
REQ-020 SHALL transfer a request on imem_req_valid & imem_req_ready; pc SHALL then advance by 4 (32-bit wrap).
REQ-021 SHALL assert imem_req_valid only when !stall, !redirect_valid, and (occupancy + in-flight) < DEPTH.
REQ-022 SHALL hold imem_req_addr stable while imem_req_valid is high and imem_req_ready is low.
REQ-023 SHALL push {pc_of_request, imem_rsp_data} into a FIFO on each non-discarded response; a request's PC SHALL be tracked in a DEPTH-entry in-flight PC FIFO.
REQ-024 SHALL drive out_valid = queue not empty, with out_instr/out_pc taken from the head; the head SHALL pop on out_valid & out_ready.
REQ-025 When the queue is empty and a response arrives, the word SHALL appear on out_* in the following cycle (1-cycle latency, no bypass).
REQ-026 Push and pop in the same cycle SHALL keep occupancy unchanged, including when the queue is full.
REQ-027 On redirect_valid, in the same edge: the queue SHALL empty, pc SHALL load {redirect_pc[31:2],2'b00}, and a discard counter SHALL load the in-flight count.
REQ-028 Responses arriving while discard counter > 0 SHALL be dropped and SHALL decrement the counter; a response in the redirect cycle itself SHALL be dropped.
REQ-029 A pop coincident with redirect_valid SHALL count as accepted; the queue is still flushed.
REQ-030 misalign_err SHALL pulse in the cycle redirect_valid is high with redirect_pc[1:0] != 0.
REQ-031 stall SHALL NOT block responses or pops; in-flight requests SHALL complete.
REQ-032 Occupancy + in-flight SHALL never exceed DEPTH; responses SHALL never be lost except by discard.

Reset
REQ-033 On rst_n=1 at a clock edge: pc=RESET_PC, queue empty, in-flight=0, discard=0, out_valid=0, imem_req_valid=0, misalign_err=0; out_instr/out_pc SHALL read 32'h0000_0013 and 0.
REQ-034 Reset SHALL dominate redirect_valid and any response in the same cycle; responses after reset deassertion for pre-reset requests are the memory's responsibility and are not tracked.

Structure
REQ-035 NOP encoding (32'h0000_0013) and the fetch-entry struct {pc, instr} SHALL live in the shared pipeline package.
REQ-036 A parameterized sync FIFO sub-module, fetch_fifo, SHALL implement both the queue and the in-flight PC FIFO.

Verification
REQ-037 Reset, zero-wait memory, out_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles after the first response.
REQ-038 out_ready=0 for 6 cycles -> exactly DEPTH (2) entries queued, imem_req_valid=0, no lost words after release.
REQ-039 Two requests in flight, redirect to 32'h0000_0100 -> both responses dropped, next out_pc=32'h100.
REQ-040 Redirect with a response in the same cycle plus a pop -> popped entry accepted, response dropped, queue empty next cycle.
REQ-041 redirect_pc=32'h0000_0102 -> misalign_err pulses 1 cycle, fetch resumes at 32'h100.
REQ-042 stall=1 with 1 in flight, imem_req_ready random -> response queued, no new request until stall=0.
